// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: load-type encodings, load FSM states and
// the MEM->ID forwarding bus layout.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ld_state_e;

  localparam int MEM_TO_ID_WD = 38;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side bundle of the MEM stage: controller holds, EX inputs,
// data-SRAM load return, forwarding bus and MEM->WB outputs.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
);
  logic                    stall_ex_i;
  logic                    stall_mem_i;
  logic                    stall_wb_i;
  logic                    flush_i;
  logic                    ex_valid_i;
  logic [DW-1:0]           ex_pc_i;
  logic                    ex_rf_we_i;
  logic [4:0]              ex_rf_waddr_i;
  logic [DW-1:0]           ex_result_i;
  logic                    ex_load_i;
  logic [2:0]              ex_load_type_i;
  logic                    data_sram_rvalid_i;
  logic [31:0]             data_sram_rdata_i;
  logic                    stallreq_mem_o;
  logic                    mem_load_pending_o;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus_o;
  logic                    wb_valid_o;
  logic [DW-1:0]           wb_pc_o;
  logic                    wb_rf_we_o;
  logic [4:0]              wb_rf_waddr_o;
  logic [DW-1:0]           wb_rf_wdata_o;

  modport master (
    output stall_ex_i, stall_mem_i, stall_wb_i, flush_i,
    output ex_valid_i, ex_pc_i, ex_rf_we_i, ex_rf_waddr_i, ex_result_i,
    output ex_load_i, ex_load_type_i, data_sram_rvalid_i, data_sram_rdata_i,
    input  stallreq_mem_o, mem_load_pending_o, mem_to_id_bus_o,
    input  wb_valid_o, wb_pc_o, wb_rf_we_o, wb_rf_waddr_o, wb_rf_wdata_o
  );

  modport slave (
    input  stall_ex_i, stall_mem_i, stall_wb_i, flush_i,
    input  ex_valid_i, ex_pc_i, ex_rf_we_i, ex_rf_waddr_i, ex_result_i,
    input  ex_load_i, ex_load_type_i, data_sram_rvalid_i, data_sram_rdata_i,
    output stallreq_mem_o, mem_load_pending_o, mem_to_id_bus_o,
    output wb_valid_o, wb_pc_o, wb_rf_we_o, wb_rf_waddr_o, wb_rf_wdata_o
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half from the SRAM word and
// sign- or zero-extends it; addr[0] is ignored for halfword loads.
module load_align
  import mem_stage_pkg::*;
(
  input  load_type_e  i_type,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    unique case (i_type)
      LT_LB:   o_wdata = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_wdata = {24'd0, w_byte};
      LT_LH:   o_wdata = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_wdata = {16'd0, w_half};
      default: o_wdata = i_rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage CPU: EX->MEM register, load-return tracking FSM
// with stall request, forwarding bus to ID and the MEM->WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input logic       clk,
  input logic       resetn,
  mem_stage_if.slave bus
);
  logic          r_vld_p0;
  logic [DW-1:0] r_pc_p0;
  logic          r_rf_we_p0;
  logic [4:0]    r_waddr_p0;
  logic [DW-1:0] r_result_p0;
  logic          r_load_p0;
  load_type_e    r_ltype_p0;

  ld_state_e     r_state;
  ld_state_e     w_state_nxt;
  logic          r_drop;
  logic [DW-1:0] r_hold_data;

  logic          r_vld_p1;
  logic [DW-1:0] r_pc_p1;
  logic          r_rf_we_p1;
  logic [4:0]    r_waddr_p1;
  logic [DW-1:0] r_wdata_p1;

  logic          w_mem_bubble;
  logic          w_mem_upd;
  logic          w_rv_use;
  logic          w_stallreq;
  logic          w_pending;
  logic [31:0]   w_aligned;
  logic [DW-1:0] w_mem_wdata;
  mem_to_id_t    w_mem_bus;

  assign w_mem_bubble = bus.flush_i | (bus.stall_ex_i & ~bus.stall_mem_i);
  assign w_mem_upd    = w_mem_bubble | ~bus.stall_mem_i;
  // A return while drop is set belongs to a killed load and is never used.
  assign w_rv_use     = (r_state == ST_WAIT) & bus.data_sram_rvalid_i & ~r_drop;

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p0    <= 1'b0;
      r_pc_p0     <= '0;
      r_rf_we_p0  <= 1'b0;
      r_waddr_p0  <= '0;
      r_result_p0 <= '0;
      r_load_p0   <= 1'b0;
      r_ltype_p0  <= LT_LB;
    end else if (w_mem_bubble) begin
      r_vld_p0    <= 1'b0;
      r_pc_p0     <= '0;
      r_rf_we_p0  <= 1'b0;
      r_waddr_p0  <= '0;
      r_result_p0 <= '0;
      r_load_p0   <= 1'b0;
      r_ltype_p0  <= LT_LB;
    end else if (!bus.stall_mem_i) begin
      r_vld_p0    <= bus.ex_valid_i;
      r_pc_p0     <= bus.ex_pc_i;
      r_rf_we_p0  <= bus.ex_rf_we_i;
      r_waddr_p0  <= bus.ex_rf_waddr_i;
      r_result_p0 <= bus.ex_result_i;
      r_load_p0   <= bus.ex_load_i;
      r_ltype_p0  <= load_type_e'(bus.ex_load_type_i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mem_upd) begin
      w_state_nxt = (!w_mem_bubble && bus.ex_valid_i && bus.ex_load_i) ? ST_WAIT : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_WAIT: if (w_rv_use) w_state_nxt = ST_HOLD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_stallreq  = 1'b0;
    w_pending   = 1'b0;
    w_mem_wdata = r_result_p0;
    unique case (r_state)
      ST_WAIT: begin
        w_stallreq = ~w_rv_use;
        w_pending  = r_vld_p0 & r_load_p0 & ~w_rv_use;
        if (w_rv_use) w_mem_wdata = w_aligned;
      end
      ST_HOLD: w_mem_wdata = r_hold_data;
      default: w_mem_wdata = r_result_p0;
    endcase
  end

  // A flush in WAIT leaves one return in flight that must be swallowed,
  // unless that return is arriving in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop      <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_drop <= (r_drop & ~bus.data_sram_rvalid_i)
              | (bus.flush_i & (r_state == ST_WAIT) & ~w_rv_use);
      if (w_rv_use) r_hold_data <= w_aligned;
    end
  end

  load_align u_load_align (
    .i_type  (r_ltype_p0),
    .i_addr  (r_result_p0[1:0]),
    .i_rdata (bus.data_sram_rdata_i),
    .o_wdata (w_aligned)
  );

  assign w_mem_bus.rf_we    = r_vld_p0 & r_rf_we_p0 & ~w_pending;
  assign w_mem_bus.rf_waddr = r_waddr_p0;
  assign w_mem_bus.rf_wdata = w_mem_wdata;

  assign bus.stallreq_mem_o     = w_stallreq;
  assign bus.mem_load_pending_o = w_pending;
  assign bus.mem_to_id_bus_o    = w_mem_bus;

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p1   <= 1'b0;
      r_pc_p1    <= '0;
      r_rf_we_p1 <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
    end else if (bus.stall_mem_i && !bus.stall_wb_i) begin
      r_vld_p1   <= 1'b0;
      r_pc_p1    <= '0;
      r_rf_we_p1 <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
    end else if (!bus.stall_wb_i) begin
      r_vld_p1   <= r_vld_p0;
      r_pc_p1    <= r_pc_p0;
      r_rf_we_p1 <= r_rf_we_p0;
      r_waddr_p1 <= r_waddr_p0;
      r_wdata_p1 <= w_mem_wdata;
    end
  end

  assign bus.wb_valid_o    = r_vld_p1;
  assign bus.wb_pc_o       = r_pc_p1;
  assign bus.wb_rf_we_o    = r_rf_we_p1;
  assign bus.wb_rf_waddr_o = r_waddr_p1;
  assign bus.wb_rf_wdata_o = r_wdata_p1;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push their expected
// write-back into a queue; a monitor pops and compares on every valid WB.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic xstall = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  wb_t  exp_q[$];

  mem_stage_if #(.DW(32)) bus ();

  mem_stage #(.DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // The bench plays the pipeline controller: stall requests fold into EX/MEM.
  assign bus.stall_mem_i = xstall | bus.stallreq_mem_o;
  assign bus.stall_ex_i  = bus.stall_mem_i;
  assign bus.stall_wb_i  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                       input logic [31:0] res, input logic ld, input logic [2:0] lt);
    bus.ex_valid_i     = 1'b1;
    bus.ex_pc_i        = pc;
    bus.ex_rf_we_i     = we;
    bus.ex_rf_waddr_i  = wa;
    bus.ex_result_i    = res;
    bus.ex_load_i      = ld;
    bus.ex_load_type_i = lt;
  endtask

  task automatic clear_ex();
    bus.ex_valid_i     = 1'b0;
    bus.ex_pc_i        = '0;
    bus.ex_rf_we_i     = 1'b0;
    bus.ex_rf_waddr_i  = '0;
    bus.ex_result_i    = '0;
    bus.ex_load_i      = 1'b0;
    bus.ex_load_type_i = '0;
  endtask

  task automatic expect_wb(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] d);
    wb_t e;
    e.pc = pc; e.we = 1'b1; e.waddr = wa; e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Zero-wait load: rvalid in the cycle after capture, no stall expected.
  task automatic load0(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] addr,
                       input logic [2:0] lt, input logic [31:0] rdata, input logic [31:0] ev);
    issue(pc, 1'b1, wa, addr, 1'b1, lt);
    expect_wb(pc, wa, ev);
    step();
    clear_ex();
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = rdata;
    mid();
    chk("load0_stallreq", bus.stallreq_mem_o, 0);
    chk("load0_pending", bus.mem_load_pending_o, 0);
    chk("load0_bus", bus.mem_to_id_bus_o, {1'b1, wa, ev});
    step();
    bus.data_sram_rvalid_i = 1'b0;
    bus.data_sram_rdata_i  = '0;
  endtask

  always @(negedge clk) begin
    wb_t act, e;
    if (resetn && bus.wb_valid_o) begin
      act = {bus.wb_pc_o, bus.wb_rf_we_o, bus.wb_rf_waddr_o, bus.wb_rf_wdata_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got 0x%0h expected no write-back", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_errors++;
          $display("FAIL wb_data: got pc=0x%0h we=%0b rd=%0d d=0x%0h expected pc=0x%0h we=%0b rd=%0d d=0x%0h",
                   act.pc, act.we, act.waddr, act.wdata, e.pc, e.we, e.waddr, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.flush_i            = 1'b0;
    bus.data_sram_rvalid_i = 1'b0;
    bus.data_sram_rdata_i  = '0;
    clear_ex();
    #1 resetn = 1'b0;
    mid();
    chk("rst_stallreq", bus.stallreq_mem_o, 0);
    chk("rst_pending", bus.mem_load_pending_o, 0);
    chk("rst_bus", bus.mem_to_id_bus_o, 0);
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_wb_wdata", bus.wb_rf_wdata_o, 0);
    step();
    resetn = 1'b1;
    step();

    // ADD r5 = 0x1234
    issue(32'h100, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000);
    expect_wb(32'h100, 5'd5, 32'h0000_1234);
    step();
    clear_ex();
    mid();
    chk("add_bus", bus.mem_to_id_bus_o, {1'b1, 5'd5, 32'h0000_1234});
    chk("add_stallreq", bus.stallreq_mem_o, 0);
    step();
    mid();
    chk("add_stallreq_wb", bus.stallreq_mem_o, 0);

    // zero-wait alignment vectors
    load0(32'h110, 5'd6, 32'h0000_1001, LT_LB,  32'h1280_FF00, 32'hFFFF_FFFF);
    load0(32'h114, 5'd7, 32'h0000_1001, LT_LBU, 32'h1280_FF00, 32'h0000_00FF);
    load0(32'h118, 5'd8, 32'h0000_1002, LT_LHU, 32'h1280_FF00, 32'h0000_1280);
    load0(32'h11C, 5'd9, 32'h0000_1002, LT_LH,  32'h8000_1234, 32'hFFFF_8000);
    load0(32'h120, 5'd4, 32'h0000_1003, LT_LB,  32'h7F00_0000, 32'h0000_007F);
    load0(32'h124, 5'd3, 32'h0000_1000, LT_LHU, 32'h1234_BEEF, 32'h0000_BEEF);

    // LW with three wait cycles
    issue(32'h200, 1'b1, 5'd9, 32'h0000_2000, 1'b1, LT_LW);
    expect_wb(32'h200, 5'd9, 32'hDEAD_BEEF);
    step();
    clear_ex();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      if (bus.stallreq_mem_o) cnt++;
      chk("lw3_pending", bus.mem_load_pending_o, 1);
      chk("lw3_bus_we", bus.mem_to_id_bus_o[37], 0);
      chk("lw3_wb_bubble", bus.wb_valid_o, 0);
      step();
    end
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = 32'hDEAD_BEEF;
    mid();
    chk("lw3_stallreq_end", bus.stallreq_mem_o, 0);
    chk("lw3_bus", bus.mem_to_id_bus_o, {1'b1, 5'd9, 32'hDEAD_BEEF});
    step();
    bus.data_sram_rvalid_i = 1'b0;
    chk("lw3_stall_cycles", cnt, 3);

    // return arrives while MEM is held by another cause -> HOLD
    issue(32'h300, 1'b1, 5'd10, 32'h0000_3000, 1'b1, LT_LW);
    expect_wb(32'h300, 5'd10, 32'hCAFE_F00D);
    step();
    clear_ex();
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = 32'hCAFE_F00D;
    xstall = 1'b1;
    mid();
    chk("hold_stallreq", bus.stallreq_mem_o, 0);
    step();
    bus.data_sram_rvalid_i = 1'b0;
    bus.data_sram_rdata_i  = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("hold_stallreq2", bus.stallreq_mem_o, 0);
      chk("hold_pending", bus.mem_load_pending_o, 0);
      chk("hold_bus", bus.mem_to_id_bus_o, {1'b1, 5'd10, 32'hCAFE_F00D});
      chk("hold_wb_bubble", bus.wb_valid_o, 0);
      step();
    end
    xstall = 1'b0;
    mid();
    chk("hold_bus_rel", bus.mem_to_id_bus_o, {1'b1, 5'd10, 32'hCAFE_F00D});
    step();
    bus.data_sram_rdata_i = '0;

    // flush during WAIT, stale return dropped, new LW gets the next one
    issue(32'h400, 1'b1, 5'd11, 32'h0000_4000, 1'b1, LT_LW);
    step();
    clear_ex();
    mid();
    chk("flush_wait1", bus.stallreq_mem_o, 1);
    step();
    bus.flush_i = 1'b1;
    mid();
    chk("flush_wait2", bus.stallreq_mem_o, 1);
    step();
    bus.flush_i = 1'b0;
    issue(32'h404, 1'b1, 5'd12, 32'h0000_4004, 1'b1, LT_LW);
    expect_wb(32'h404, 5'd12, 32'h2222_2222);
    mid();
    chk("flush_idle_stallreq", bus.stallreq_mem_o, 0);
    chk("flush_bubble_bus", bus.mem_to_id_bus_o, 0);
    step();
    clear_ex();
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = 32'h1111_1111;
    mid();
    chk("stale_stallreq", bus.stallreq_mem_o, 1);
    chk("stale_pending", bus.mem_load_pending_o, 1);
    step();
    bus.data_sram_rdata_i = 32'h2222_2222;
    mid();
    chk("fresh_stallreq", bus.stallreq_mem_o, 0);
    chk("fresh_bus", bus.mem_to_id_bus_o, {1'b1, 5'd12, 32'h2222_2222});
    step();
    bus.data_sram_rvalid_i = 1'b0;

    // simultaneous flush and return: discarded, drop stays clear
    issue(32'h500, 1'b1, 5'd13, 32'h0000_5000, 1'b1, LT_LW);
    step();
    clear_ex();
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = 32'h3333_3333;
    bus.flush_i = 1'b1;
    xstall = 1'b1;
    mid();
    chk("simul_stallreq", bus.stallreq_mem_o, 0);
    step();
    bus.data_sram_rvalid_i = 1'b0;
    bus.flush_i = 1'b0;
    xstall = 1'b0;
    issue(32'h504, 1'b1, 5'd14, 32'h0000_5004, 1'b1, LT_LW);
    expect_wb(32'h504, 5'd14, 32'h4444_4444);
    step();
    clear_ex();
    bus.data_sram_rvalid_i = 1'b1;
    bus.data_sram_rdata_i  = 32'h4444_4444;
    mid();
    chk("simul_next_stallreq", bus.stallreq_mem_o, 0);
    chk("simul_next_bus", bus.mem_to_id_bus_o, {1'b1, 5'd14, 32'h4444_4444});
    step();
    bus.data_sram_rvalid_i = 1'b0;

    // reset pulsed mid-WAIT
    issue(32'h600, 1'b1, 5'd15, 32'h0000_6000, 1'b1, LT_LW);
    step();
    clear_ex();
    mid();
    chk("rstw_stallreq_pre", bus.stallreq_mem_o, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rstw_stallreq", bus.stallreq_mem_o, 0);
    chk("rstw_pending", bus.mem_load_pending_o, 0);
    chk("rstw_bus", bus.mem_to_id_bus_o, 0);
    chk("rstw_wb_valid", bus.wb_valid_o, 0);
    chk("rstw_wb_pc", bus.wb_pc_o, 0);
    @(posedge clk);
    #3 resetn = 1'b1;
    step();
    mid();
    chk("rstw_idle_after", bus.stallreq_mem_o, 0);
    step();

    // normal operation after reset
    issue(32'h700, 1'b1, 5'd3, 32'h0000_ABCD, 1'b0, 3'b000);
    expect_wb(32'h700, 5'd3, 32'h0000_ABCD);
    step();
    clear_ex();
    mid();
    chk("post_rst_bus", bus.mem_to_id_bus_o, {1'b1, 5'd3, 32'h0000_ABCD});
    repeat (4) step();
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
